plugboard: RTL and testbench

Upstream stage of the rotor stack: substitutes each incoming ASCII letter through a reconfigurable set of up to 10 symmetric letter pairs (Steckerbrett) and hands the result, with a one-cycle `done` pulse, to the first rotor's `din`/`valid`. Pair configuration is loaded one pair at a time with validity checking; unplugged letters pass through unchanged. The same mapping serves both encode and decode because it is an involution.

---
 rtl/plugboard_if.sv | 38 +++
 rtl/plugboard.sv | 168 ++++++++++++++++
 tb/tb_plugboard.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/plugboard_if.sv
// plugboard_if - character / pair-configuration bundle for the plugboard.
//   master : upstream driver (clear, pair_valid, pair_a, pair_b, valid, din[, unplug])
//   slave  : plugboard (ready, dout, done, cfg_ack, cfg_err, char_err, pair_cnt)
// Optional: PLUGBOARD_UNPLUG_EN adds the 'unplug' qualifier for pair removal.
interface plugboard_if;
    logic       clear;
    logic       pair_valid;
    logic [7:0] pair_a;
    logic [7:0] pair_b;
    logic       valid;
    logic [7:0] din;
`ifdef PLUGBOARD_UNPLUG_EN
    logic       unplug;
`endif
    logic       ready;
    logic [7:0] dout;
    logic       done;
    logic       cfg_ack;
    logic       cfg_err;
    logic       char_err;
    logic [3:0] pair_cnt;

    modport master (
`ifdef PLUGBOARD_UNPLUG_EN
        output unplug,
`endif
        output clear, pair_valid, pair_a, pair_b, valid, din,
        input  ready, dout, done, cfg_ack, cfg_err, char_err, pair_cnt
    );

    modport slave (
`ifdef PLUGBOARD_UNPLUG_EN
        input  unplug,
`endif
        input  clear, pair_valid, pair_a, pair_b, valid, din,
        output ready, dout, done, cfg_ack, cfg_err, char_err, pair_cnt
    );
endinterface

// File: rtl/plugboard.sv
// plugboard - Steckerbrett letter substitution ahead of the rotor stack.
// Up to MAX_PAIRS symmetric letter pairs, loaded one at a time with validity
// checking; unplugged letters and non-letters pass through unchanged.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   bus   - plugboard_if.slave (strobes in; ready/dout/done/cfg_ack/cfg_err/
//           char_err/pair_cnt out)
// Optional: define PLUGBOARD_UNPLUG_EN to allow removal of a single pair via
// pair_valid with bus.unplug = 1.
//
// state | meaning
// IDLE  | ready; samples clear > pair_valid > valid
// CHECK | validate latched pair, update table, pulse cfg_ack/cfg_err
// LOOK  | read table entry for latched character
// OUT   | register dout/done/char_err
module plugboard #(
    parameter int MAX_PAIRS = 10
) (
    input  logic       clk,
    input  logic       reset,
    plugboard_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, LOOK, OUT} state_t;

    localparam logic [7:0] ASCII_A = 8'd65;
    localparam logic [7:0] ASCII_Z = 8'd90;
    localparam logic [3:0] MAX_CNT = 4'(MAX_PAIRS);

    state_t     state_q, state_d;
    logic [4:0] table_q [26];
    logic [4:0] table_d [26];
    logic [3:0] pair_cnt_q, pair_cnt_d;
    logic [7:0] a_q, a_d, b_q, b_d, din_q, din_d;
    logic [7:0] look_q, look_d, dout_q, dout_d;
    logic       done_q, done_d, ack_q, ack_d, err_q, err_d, cerr_q, cerr_d;
`ifdef PLUGBOARD_UNPLUG_EN
    logic       unplug_q, unplug_d;
`endif

    logic       a_ok, b_ok, d_ok;
    logic [4:0] a_idx, b_idx, d_idx;

    // Range-check first; an out-of-range byte maps to index 0 so the table
    // is never addressed outside 0..25 (its result is then unused).
    assign a_ok  = (a_q >= ASCII_A) && (a_q <= ASCII_Z);
    assign b_ok  = (b_q >= ASCII_A) && (b_q <= ASCII_Z);
    assign d_ok  = (din_q >= ASCII_A) && (din_q <= ASCII_Z);
    assign a_idx = a_ok ? 5'(a_q - ASCII_A) : 5'd0;
    assign b_idx = b_ok ? 5'(b_q - ASCII_A) : 5'd0;
    assign d_idx = d_ok ? 5'(din_q - ASCII_A) : 5'd0;

    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        pair_cnt_d = pair_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        din_d      = din_q;
        look_d     = look_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        cerr_d     = cerr_q;
`ifdef PLUGBOARD_UNPLUG_EN
        unplug_d   = unplug_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    for (int i = 0; i < 26; i++) table_d[i] = 5'(i);
                    pair_cnt_d = 4'd0;
                end else if (bus.pair_valid) begin
                    a_d     = bus.pair_a;
                    b_d     = bus.pair_b;
`ifdef PLUGBOARD_UNPLUG_EN
                    unplug_d = bus.unplug;
`endif
                    state_d = CHECK;
                end else if (bus.valid) begin
                    din_d   = bus.din;
                    state_d = LOOK;
                end
            end
            CHECK: begin
                state_d = IDLE;
`ifdef PLUGBOARD_UNPLUG_EN
                if (unplug_q) begin
                    if (a_ok && b_ok && (a_q != b_q) && (table_q[a_idx] == b_idx)) begin
                        table_d[a_idx] = a_idx;
                        table_d[b_idx] = b_idx;
                        pair_cnt_d     = pair_cnt_q - 4'd1;
                        ack_d          = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else
`endif
                if (a_ok && b_ok && (a_q != b_q) && (table_q[a_idx] == a_idx)
                    && (table_q[b_idx] == b_idx) && (pair_cnt_q != MAX_CNT)) begin
                    table_d[a_idx] = b_idx;
                    table_d[b_idx] = a_idx;
                    pair_cnt_d     = pair_cnt_q + 4'd1;
                    ack_d          = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            LOOK: begin
                look_d  = d_ok ? ({3'b000, table_q[d_idx]} + ASCII_A) : din_q;
                state_d = OUT;
            end
            OUT: begin
                dout_d  = look_q;
                cerr_d  = ~d_ok;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < 26; i++) table_q[i] <= 5'(i);
            pair_cnt_q <= 4'd0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            din_q      <= 8'h00;
            look_q     <= 8'h00;
            dout_q     <= 8'h00;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            cerr_q     <= 1'b0;
`ifdef PLUGBOARD_UNPLUG_EN
            unplug_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            pair_cnt_q <= pair_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            din_q      <= din_d;
            look_q     <= look_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            // char_err is a qualifier of done; it drops with the pulse.
            cerr_q     <= cerr_d & done_d;
`ifdef PLUGBOARD_UNPLUG_EN
            unplug_q   <= unplug_d;
`endif
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.dout     = dout_q;
    assign bus.done     = done_q;
    assign bus.cfg_ack  = ack_q;
    assign bus.cfg_err  = err_q;
    assign bus.char_err = cerr_q;
    assign bus.pair_cnt = pair_cnt_q;
endmodule

// File: tb/tb_plugboard.sv
// tb_plugboard - directed, scoreboard-checked bench for plugboard.
// Stimulus pushes the expected response; a negedge monitor pops and compares
// every done/cfg_ack/cfg_err pulse. Optional block built with PLUGBOARD_UNPLUG_EN.
module tb_plugboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plugboard_if bus ();
    plugboard #(.MAX_PAIRS(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    // pulse: {done, cfg_ack, cfg_err}
    typedef struct packed {
        logic [2:0] pulse;
        logic [7:0] dout;
        logic       cerr;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.done || bus.cfg_ack || bus.cfg_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, bus.done, bus.cfg_ack, bus.cfg_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_kind", {29'd0, bus.done, bus.cfg_ack, bus.cfg_err}, {29'd0, e.pulse});
                if (e.pulse == 3'b100) begin
                    chk("dout", {24'd0, bus.dout}, {24'd0, e.dout});
                    chk("char_err", {31'd0, bus.char_err}, {31'd0, e.cerr});
                end
                chk("pair_cnt", {28'd0, bus.pair_cnt}, {28'd0, e.cnt});
            end
        end
    end

    task automatic send_char(input logic [7:0] c, input logic [7:0] exp_d,
                             input logic exp_err, input logic [3:0] exp_cnt);
        sb_q.push_back({3'b100, exp_d, exp_err, exp_cnt});
        @(negedge clk); bus.valid = 1'b1; bus.din = c;
        @(negedge clk); bus.valid = 1'b0;
        chk("char_ready_lo1", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);
        chk("char_ready_lo2", {31'd0, bus.ready}, 32'd0);
        chk("char_done_early", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        chk("char_done_lat", {31'd0, bus.done}, 32'd1);
        chk("char_ready_hi", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic unp,
                             input logic ok, input logic [3:0] exp_cnt);
        sb_q.push_back({ok ? 3'b010 : 3'b001, 8'h00, 1'b0, exp_cnt});
        @(negedge clk);
        bus.pair_valid = 1'b1; bus.pair_a = a; bus.pair_b = b;
`ifdef PLUGBOARD_UNPLUG_EN
        bus.unplug = unp;
`else
        if (unp) $display("unplug requested without PLUGBOARD_UNPLUG_EN");
`endif
        @(negedge clk); bus.pair_valid = 1'b0;
        chk("pair_ready_lo", {31'd0, bus.ready}, 32'd0);
        chk("pair_pulse_early", {31'd0, bus.cfg_ack | bus.cfg_err}, 32'd0);
        @(negedge clk);
        chk("pair_pulse_lat", {31'd0, bus.cfg_ack | bus.cfg_err}, 32'd1);
        chk("pair_ready_hi", {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.clear = 1'b0; bus.pair_valid = 1'b0; bus.valid = 1'b0;
        bus.pair_a = 8'h00; bus.pair_b = 8'h00; bus.din = 8'h00;
`ifdef PLUGBOARD_UNPLUG_EN
        bus.unplug = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_dout", {24'd0, bus.dout}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ack_err", {30'd0, bus.cfg_ack, bus.cfg_err}, 32'd0);
        chk("rst_char_err", {31'd0, bus.char_err}, 32'd0);
        chk("rst_pair_cnt", {28'd0, bus.pair_cnt}, 32'd0);

        send_char("Q", "Q", 1'b0, 4'd0);

        send_pair("A", "Z", 1'b0, 1'b1, 4'd1);
        send_char("A", "Z", 1'b0, 4'd1);
        send_char("Z", "A", 1'b0, 4'd1);
        send_char("B", "B", 1'b0, 4'd1);

        send_pair("A", "B", 1'b0, 1'b0, 4'd1);
        send_char("B", "B", 1'b0, 4'd1);
        send_pair("C", "C", 1'b0, 1'b0, 4'd1);
        send_pair(8'd97, "B", 1'b0, 1'b0, 4'd1);
        send_char("A", "Z", 1'b0, 4'd1);

        send_pair("B", "C", 1'b0, 1'b1, 4'd2);
        send_pair("D", "E", 1'b0, 1'b1, 4'd3);
        send_pair("F", "G", 1'b0, 1'b1, 4'd4);
        send_pair("H", "I", 1'b0, 1'b1, 4'd5);
        send_pair("J", "K", 1'b0, 1'b1, 4'd6);
        send_pair("L", "M", 1'b0, 1'b1, 4'd7);
        send_pair("N", "O", 1'b0, 1'b1, 4'd8);
        send_pair("P", "Q", 1'b0, 1'b1, 4'd9);
        send_pair("R", "S", 1'b0, 1'b1, 4'd10);
        send_pair("T", "U", 1'b0, 1'b0, 4'd10);
        send_char("S", "R", 1'b0, 4'd10);
        send_char("B", "C", 1'b0, 4'd10);
        send_char("T", "T", 1'b0, 4'd10);

        send_char(8'd97, 8'd97, 1'b1, 4'd10);

        // second valid held through LOOK and OUT must be dropped
        sb_q.push_back({3'b100, 8'd90, 1'b0, 4'd10});
        @(negedge clk); bus.valid = 1'b1; bus.din = "A";
        @(negedge clk); bus.din = "C";
        @(negedge clk);
        @(negedge clk); bus.valid = 1'b0;
        chk("drop_done", {31'd0, bus.done}, 32'd1);
        repeat (5) @(negedge clk);

        // clear wins over pair_valid and valid in the same cycle
        @(negedge clk);
        bus.clear = 1'b1; bus.pair_valid = 1'b1; bus.pair_a = "T"; bus.pair_b = "U";
        bus.valid = 1'b1; bus.din = "A";
        @(negedge clk);
        bus.clear = 1'b0; bus.pair_valid = 1'b0; bus.valid = 1'b0;
        chk("clr_ready", {31'd0, bus.ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("clr_pair_cnt", {28'd0, bus.pair_cnt}, 32'd0);
        send_char("A", "A", 1'b0, 4'd0);
        send_char("S", "S", 1'b0, 4'd0);

        // reset while in LOOK
        send_pair("A", "Z", 1'b0, 1'b1, 4'd1);
        @(negedge clk); bus.valid = 1'b1; bus.din = "A";
        @(negedge clk); bus.valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_look_done", {31'd0, bus.done}, 32'd0);
        chk("rst_look_cnt", {28'd0, bus.pair_cnt}, 32'd0);
        send_char("A", "A", 1'b0, 4'd0);

`ifdef PLUGBOARD_UNPLUG_EN
        send_pair("A", "Z", 1'b0, 1'b1, 4'd1);
        send_pair("D", "E", 1'b0, 1'b1, 4'd2);
        send_pair("A", "E", 1'b1, 1'b0, 4'd2);
        send_pair("A", "Z", 1'b1, 1'b1, 4'd1);
        send_pair("A", "Z", 1'b1, 1'b0, 4'd1);
        send_char("A", "A", 1'b0, 4'd1);
        send_char("E", "D", 1'b0, 4'd1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
